// File: rtl/ram_fifo_ctrl_if.sv
// Bundle of the push stream, pop stream, level and RAM port signals.
// master: FIFO controller side. slave: producer/consumer/RAM side.
interface ram_fifo_ctrl_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [DEPTH:0]   level;
   logic             ram_enable;
   logic             ram_wr_en;
   logic [DEPTH-1:0] ram_address;
   logic [WIDTH-1:0] ram_data_in;
   logic [WIDTH-1:0] ram_data_out;

   modport master (
      input  in_valid, in_data, out_ready, ram_data_out,
      output in_ready, out_valid, out_data, level,
      output ram_enable, ram_wr_en, ram_address, ram_data_in
   );

   modport slave (
      output in_valid, in_data, out_ready, ram_data_out,
      input  in_ready, out_valid, out_data, level,
      input  ram_enable, ram_wr_en, ram_address, ram_data_in
   );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller that owns a single-port sync RAM.
// Ports: clk, rst_n (async low), bus (push/pop streams, level, RAM drive).
module ram_fifo_ctrl #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input logic             clk,
   input logic             rst_n,
   ram_fifo_ctrl_if.master bus
);

   localparam logic [DEPTH:0] LP_FULL = {1'b1, {DEPTH{1'b0}}};

   logic [DEPTH-1:0] r_wr_ptr;
   logic [DEPTH-1:0] r_rd_ptr;
   logic [DEPTH:0]   r_count;
   logic             r_rd_pending;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;

   logic w_rd_issue;
   logic w_wr_issue;
   logic w_in_ready;

   // A read may only start when the output register is free by the
   // time its data lands (free now, or being popped this cycle).
   assign w_rd_issue = (r_count != '0) && !r_rd_pending &&
                       (!r_out_valid || bus.out_ready);

   // Reads win the single RAM port; a blocked push simply retries.
   assign w_in_ready = rst_n && (r_count != LP_FULL) && !w_rd_issue;
   assign w_wr_issue = bus.in_valid && w_in_ready;

   assign bus.in_ready    = w_in_ready;
   assign bus.out_valid   = r_out_valid;
   assign bus.out_data    = r_out_data;
   assign bus.level       = r_count
                          + {{DEPTH{1'b0}}, r_rd_pending}
                          + {{DEPTH{1'b0}}, r_out_valid};

   assign bus.ram_enable  = rst_n && (w_rd_issue || w_wr_issue);
   assign bus.ram_wr_en   = rst_n && w_wr_issue;
   assign bus.ram_address = !rst_n     ? '0 :
                            w_wr_issue ? r_wr_ptr : r_rd_ptr;
   assign bus.ram_data_in = rst_n ? bus.in_data : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_rd_pending <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
      end else begin
         if (w_wr_issue) begin
            r_wr_ptr <= r_wr_ptr + DEPTH'(1);
            r_count  <= r_count + (DEPTH+1)'(1);
         end
         if (w_rd_issue) begin
            r_rd_ptr <= r_rd_ptr + DEPTH'(1);
            r_count  <= r_count - (DEPTH+1)'(1);
         end
         // Pending never overlaps an issue, so this both sets and clears.
         r_rd_pending <= w_rd_issue;
         if (r_rd_pending) begin
            r_out_data  <= bus.ram_data_out;
            r_out_valid <= 1'b1;
         end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl with a behavioural RAM and a queue scoreboard.
// Directed phases followed by randomized backpressure traffic.
module tb_ram_fifo_ctrl;

   logic clk;
   logic rst_n;
   logic [7:0] mem [16];

   ram_fifo_ctrl_if #(.WIDTH(8), .DEPTH(4)) bif ();

   ram_fifo_ctrl #(.WIDTH(8), .DEPTH(4)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port synchronous RAM: registered read data.
   always @(posedge clk) begin
      if (bif.ram_enable) begin
         if (bif.ram_wr_en) mem[bif.ram_address] <= bif.ram_data_in;
         else bif.ram_data_out <= mem[bif.ram_address];
      end
   end

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] q[$];
   int wr_n = 0;
   int rd_n = 0;
   logic last_rd = 1'b0;
   logic last_push = 1'b0;
   logic [7:0] last_pop = '0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic r);
      bif.in_valid  = v;
      bif.in_data   = d;
      bif.out_ready = r;
      #1;
   endtask

   // Check one cycle against the scoreboard, then advance to next negedge.
   task automatic cyc();
      logic push;
      logic pop;
      logic rd;
      logic [7:0] e;
      push = bif.in_valid && bif.in_ready;
      pop  = bif.out_valid && bif.out_ready;
      rd   = bif.ram_enable && !bif.ram_wr_en;
      chk("level", 32'(bif.level), 32'(q.size()));
      if (wr_n - rd_n == 16) chk("full_stall", 32'(bif.in_ready), 0);
      chk("wr_en", 32'(bif.ram_wr_en), 32'(push));
      if (bif.ram_enable && bif.ram_wr_en) begin
         chk("wr_addr", 32'(bif.ram_address), 32'(wr_n % 16));
         chk("wr_data", 32'(bif.ram_data_in), 32'(bif.in_data));
      end
      if (rd) begin
         chk("rd_addr", 32'(bif.ram_address), 32'(rd_n % 16));
         chk("rd_nonempty", 32'(wr_n - rd_n > 0), 1);
         rd_n++;
      end
      if (pop) begin
         if (q.size() == 0) begin
            chk("pop_underflow", 32'(bif.out_valid), 0);
         end else begin
            e = q.pop_front();
            chk("pop_data", 32'(bif.out_data), 32'(e));
            last_pop = bif.out_data;
         end
      end
      if (push) begin
         q.push_back(bif.in_data);
         wr_n++;
      end
      last_rd = rd;
      last_push = push;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push_until(input logic [7:0] d, input logic r,
                             input int maxc, output logic acc);
      acc = 1'b0;
      for (int i = 0; i < maxc && !acc; i++) begin
         drive(1'b1, d, r);
         acc = bif.in_ready;
         cyc();
      end
   endtask

   task automatic drain();
      drive(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 100 && bif.level != 0; i++) begin
         cyc();
         drive(1'b0, 8'h00, 1'b1);
      end
      chk("drain_level", 32'(bif.level), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc;
      logic [7:0] v;
      int pushed;
      rst_n = 1'b0;
      bif.in_valid = 1'b0;
      bif.in_data = '0;
      bif.out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_out_valid", 32'(bif.out_valid), 0);
      chk("rst_level", 32'(bif.level), 0);
      chk("rst_in_ready", 32'(bif.in_ready), 0);
      chk("rst_ram_en", 32'(bif.ram_enable), 0);
      chk("rst_out_data", 32'(bif.out_data), 0);
      rst_n = 1'b1;

      // Single word latency.
      drive(1'b1, 8'h3C, 1'b1);
      chk("sw_in_ready", 32'(bif.in_ready), 1);
      chk("sw_wr", 32'(bif.ram_wr_en), 1);
      chk("sw_wr_addr", 32'(bif.ram_address), 0);
      cyc();
      drive(1'b0, 8'h00, 1'b1);
      chk("sw_rd_en", 32'(bif.ram_enable), 1);
      chk("sw_rd_we", 32'(bif.ram_wr_en), 0);
      chk("sw_rd_addr", 32'(bif.ram_address), 0);
      cyc();
      chk("sw_n2_valid", 32'(bif.out_valid), 0);
      cyc();
      chk("sw_n3_valid", 32'(bif.out_valid), 1);
      chk("sw_n3_data", 32'(bif.out_data), 32'h3C);
      cyc();
      chk("sw_level", 32'(bif.level), 0);

      // Fill to capacity with the consumer stalled.
      for (int d = 0; d <= 16; d++) begin
         push_until(8'(d), 1'b0, 8, acc);
         chk("fill_acc", 32'(acc), 1);
      end
      push_until(8'h11, 1'b0, 8, acc);
      chk("fill_hold", 32'(acc), 0);
      drive(1'b1, 8'h11, 1'b0);
      chk("fill_level", 32'(bif.level), 17);
      chk("fill_in_ready", 32'(bif.in_ready), 0);
      chk("fill_head", 32'(bif.out_data), 32'h00);

      // Drain across the pointer wrap while still pushing.
      for (int d = 17; d < 48; d++) begin
         push_until(8'(d), 1'b1, 8, acc);
         chk("wrap_acc", 32'(acc), 1);
      end
      drain();
      chk("wrap_last", 32'(last_pop), 32'd47);

      // Arbitration: both streams continuously active.
      v = 8'h80;
      for (int i = 0; i < 40; i++) begin
         drive(1'b1, v, 1'b1);
         chk("arb_en", 32'(bif.ram_enable), 1);
         if (i > 0)
            chk("arb_alt", 32'(!bif.ram_wr_en), 32'(!last_rd));
         cyc();
         if (last_push) v = v + 8'd1;
      end
      drain();

      // Randomized backpressure.
      pushed = 0;
      for (int i = 0; i < 5000 && pushed < 200; i++) begin
         drive($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom));
         cyc();
         if (last_push) pushed++;
      end
      chk("rand_pushes", 32'(pushed), 200);
      drain();

      // Reset mid-traffic with a read in flight.
      pushed = 0;
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) begin
         drive(1'b1, 8'(8'h70 + pushed), 1'b1);
         if (pushed >= 3 && last_rd) acc = 1'b1;
         else begin
            cyc();
            if (last_push) pushed++;
         end
      end
      chk("mid_reached", 32'(acc), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_out_valid", 32'(bif.out_valid), 0);
      chk("mid_level", 32'(bif.level), 0);
      chk("mid_in_ready", 32'(bif.in_ready), 0);
      chk("mid_ram_en", 32'(bif.ram_enable), 0);
      chk("mid_ram_we", 32'(bif.ram_wr_en), 0);
      q.delete();
      wr_n = 0;
      rd_n = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 8'hA5, 1'b1);
      chk("rel_in_ready", 32'(bif.in_ready), 1);
      cyc();
      chk("rel_accept", 32'(last_push), 1);
      drain();
      chk("rel_data", 32'(last_pop), 32'hA5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Streaming FIFO controller sitting directly upstream of the single-port synchronous RAM block; it is the only master of the RAM port.
- Converts a valid/ready push stream and a valid/ready pop stream into RAM enable, write-enable, address and write-data signals.
- Consumes the RAM read data through a one-entry output register.
- Gives the rest of the design a FIFO view of the RAM without exposing addressing.

Parameters:
- WIDTH, 8, data word width; equals the RAM WIDTH.
- DEPTH, 4, RAM address width in bits; RAM holds 2**DEPTH words.

Ports:
- clk  input  1  rising-edge clock, shared with the RAM.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  push request.
- in_ready  output  1  push accepted this cycle when in_valid && in_ready.
- in_data  input  WIDTH  push word.
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  consumer takes the word when out_valid && out_ready.
- out_data  output  WIDTH  head-of-FIFO word.
- level  output  DEPTH+1  words held: RAM count + read in flight + output register.
- ram_enable  output  1  to RAM enable.
- ram_wr_en  output  1  to RAM wr_en.
- ram_address  output  DEPTH  to RAM address.
- ram_data_in  output  WIDTH  to RAM data_in.
- ram_data_out  input  WIDTH  from RAM data_out; registered, valid the cycle after a read is clocked.

Behaviour:
- State registers: wr_ptr and rd_ptr (DEPTH bits each, wrap modulo 2**DEPTH), count (DEPTH+1 bits, words resident in RAM), rd_pending (1 bit), out_valid, out_data.
- rd_issue = (count != 0) && !rd_pending && (!out_valid || out_ready).
- Reads have priority over writes. Only one RAM access is made per cycle.
- in_ready = rst_n && (count != 2**DEPTH) && !rd_issue.
- wr_issue = in_valid && in_ready.
- RAM drive, combinational:
  - ram_enable = rd_issue || wr_issue.
  - ram_wr_en = wr_issue.
  - ram_address = wr_issue ? wr_ptr : rd_ptr.
  - ram_data_in = in_data.
  - All RAM drive outputs are 0 while rst_n is low.
- On wr_issue: wr_ptr +1, count +1.
- On rd_issue: rd_ptr +1, count -1, rd_pending <= 1.
- wr_issue and rd_issue are mutually exclusive, so count never both increments and decrements.
- rd_pending cycle:
  - out_data <= ram_data_out, out_valid <= 1, rd_pending <= 0.
  - At this cycle out_valid is already 0 by construction.
- Pop (out_valid && out_ready) with no capture in the same cycle: out_valid <= 0 and out_data holds its value.
- Latency and throughput:
  - First word pushed into an empty FIFO: write in cycle N, read issued in N+1, out_valid high in N+3.
  - Sustained pop throughput is 1 word per 2 cycles.
- level = count + rd_pending + out_valid. Maximum is 2**DEPTH+1.
- Full: count == 2**DEPTH forces in_ready = 0. Pushes stall and no data is lost.
- Empty: count == 0 means no RAM access. A push still proceeds at full rate while out_valid is held with out_ready = 0.
- Pointer wrap: wr_ptr and rd_ptr pass from 2**DEPTH-1 to 0 with no gap or duplicate.
- Ordering is strict FIFO.
- Reset, async on rst_n low:
  - wr_ptr = 0, rd_ptr = 0, count = 0, rd_pending = 0, out_valid = 0, out_data = 0, level = 0, in_ready = 0.
  - An in-flight read is discarded.
  - RAM contents are not cleared; they are stale and unreachable.
- Reset release: in_ready rises combinationally. First push is accepted in the first clock edge after release.
- Simultaneous push and pop request with count != 0 and room: the read wins, in_ready = 0 that cycle, and the push retries next cycle.

Test Plan:
- Reset mid-traffic: assert rst_n low after 3 pushes with a read in flight -> out_valid, level, in_ready, ram_enable all 0 immediately. After release, a push of 8'hA5 pops as 8'hA5.
- Single word: push 8'h3C at cycle N with out_ready = 1 -> ram_wr_en = 1 at address 0 in N; read at address 0 in N+1; out_valid = 1 with out_data = 8'h3C in N+3; level returns to 0.
- Fill to capacity: out_ready = 0, push 8'h00..8'h11 continuously -> 8'h00 goes to the output register. The next 16 words fill the RAM, and level reaches 17. in_ready drops after 8'h10 is accepted, and 8'h11 is held.
- Drain and wrap: from full, pop all with out_ready = 1 and keep pushing -> data out 8'h00, 8'h01, ... with no loss or duplicate across the pointer wrap 15 -> 0.
- Arbitration: in_valid = 1 and out_ready = 1 continuously -> RAM accesses alternate read/write, never two per cycle. Outputs keep strict order.
- Backpressure: toggle out_ready randomly for 200 pushes against a scoreboard -> exact in-order match; level always equals pushes minus pops.
